// File: rtl/can_rx_frame_sequencer.sv
// CAN receive frame sequencer: walks SOF..EOF on sample-point strobes, removes
// stuff bits, checks CRC-15 and form, and presents the decoded frame fields.
module can_rx_frame_sequencer #(
    parameter int unsigned RECOVER_BITS = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        sp,
    output logic        stuff_en,
    output logic        stuff_bit,
    output logic        stuff_err,
    output logic        form_err,
    output logic        crc_err,
    output logic        frame_valid,
    output logic [28:0] id,
    output logic        ide,
    output logic        rtr,
    output logic [3:0]  dlc,
    output logic [63:0] data,
    output logic        ack_seen,
    output logic        busy,
    output logic [3:0]  state
);

    localparam int unsigned RW = (RECOVER_BITS > 1) ? $clog2(RECOVER_BITS + 1) : 1;
    localparam logic [RW-1:0] RECOVER_LAST = RW'(RECOVER_BITS - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ID_A, ST_SRR_RTR, ST_IDE, ST_ID_B, ST_RTR_X, ST_R1, ST_R0,
        ST_DLC, ST_DATA, ST_CRC, ST_CRC_DEL, ST_ACK_SLOT, ST_ACK_DEL, ST_EOF, ST_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic          run_lvl_q, run_lvl_d;
    logic [2:0]    run_cnt_q, run_cnt_d;
    logic [14:0]   crc_q, crc_d;
    logic [14:0]   crc_rx_q, crc_rx_d;
    logic          crc_bad_q, crc_bad_d;
    logic [RW-1:0] recov_q, recov_d;
    logic [28:0]   id_q, id_d;
    logic          ide_q, ide_d;
    logic          rtr_q, rtr_d;
    logic [3:0]    dlc_q, dlc_d;
    logic [63:0]   data_q, data_d;
    logic          ack_q, ack_d;
    logic          stuff_bit_q, stuff_bit_d;
    logic          stuff_err_q, stuff_err_d;
    logic          form_err_q, form_err_d;
    logic          crc_err_q, crc_err_d;
    logic          frame_valid_q, frame_valid_d;

    logic          stuffed;
    logic          stuff_slot;
    logic [6:0]    data_bits;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    assign stuffed   = (state_q >= ST_ID_A) && (state_q <= ST_CRC);
    assign data_bits = dlc_q[3] ? 7'd64 : {1'b0, dlc_q[2:0], 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            run_lvl_q     <= '0;
            run_cnt_q     <= '0;
            crc_q         <= '0;
            crc_rx_q      <= '0;
            crc_bad_q     <= '0;
            recov_q       <= '0;
            id_q          <= '0;
            ide_q         <= '0;
            rtr_q         <= '0;
            dlc_q         <= '0;
            data_q        <= '0;
            ack_q         <= '0;
            stuff_bit_q   <= '0;
            stuff_err_q   <= '0;
            form_err_q    <= '0;
            crc_err_q     <= '0;
            frame_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            run_lvl_q     <= run_lvl_d;
            run_cnt_q     <= run_cnt_d;
            crc_q         <= crc_d;
            crc_rx_q      <= crc_rx_d;
            crc_bad_q     <= crc_bad_d;
            recov_q       <= recov_d;
            id_q          <= id_d;
            ide_q         <= ide_d;
            rtr_q         <= rtr_d;
            dlc_q         <= dlc_d;
            data_q        <= data_d;
            ack_q         <= ack_d;
            stuff_bit_q   <= stuff_bit_d;
            stuff_err_q   <= stuff_err_d;
            form_err_q    <= form_err_d;
            crc_err_q     <= crc_err_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        run_lvl_d     = run_lvl_q;
        run_cnt_d     = run_cnt_q;
        crc_d         = crc_q;
        crc_rx_d      = crc_rx_q;
        crc_bad_d     = crc_bad_q;
        recov_d       = recov_q;
        id_d          = id_q;
        ide_d         = ide_q;
        rtr_d         = rtr_q;
        dlc_d         = dlc_q;
        data_d        = data_q;
        ack_d         = ack_q;
        stuff_bit_d   = 1'b0;
        stuff_err_d   = 1'b0;
        form_err_d    = 1'b0;
        crc_err_d     = 1'b0;
        frame_valid_d = 1'b0;
        stuff_slot    = 1'b0;

        if (sp) begin
            // A stuff slot consumes the sample entirely, so stuff_err pre-empts all field handling.
            if (stuffed) begin
                if (run_cnt_q == 3'd5) begin
                    stuff_slot = 1'b1;
                    if (rx == run_lvl_q) begin
                        stuff_err_d = 1'b1;
                        state_d     = ST_ERROR;
                        recov_d     = '0;
                    end else begin
                        stuff_bit_d = 1'b1;
                        run_lvl_d   = rx;
                        run_cnt_d   = 3'd1;
                    end
                end else if (rx == run_lvl_q) begin
                    run_cnt_d = run_cnt_q + 3'd1;
                end else begin
                    run_lvl_d = rx;
                    run_cnt_d = 3'd1;
                end
            end

            if (!stuff_slot) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!rx) begin
                            state_d   = ST_ID_A;
                            bit_cnt_d = '0;
                            run_lvl_d = 1'b0;
                            run_cnt_d = 3'd1;
                            crc_d     = crc_step('0, rx);
                            crc_rx_d  = '0;
                            crc_bad_d = 1'b0;
                            id_d      = '0;
                            ide_d     = 1'b0;
                            rtr_d     = 1'b0;
                            dlc_d     = '0;
                            data_d    = '0;
                            ack_d     = 1'b0;
                        end
                    end
                    ST_ID_A: begin
                        id_d      = {id_q[27:0], rx};
                        crc_d     = crc_step(crc_q, rx);
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd10) begin
                            state_d   = ST_SRR_RTR;
                            bit_cnt_d = '0;
                        end
                    end
                    ST_SRR_RTR: begin
                        rtr_d   = rx;
                        crc_d   = crc_step(crc_q, rx);
                        state_d = ST_IDE;
                    end
                    ST_IDE: begin
                        ide_d   = rx;
                        crc_d   = crc_step(crc_q, rx);
                        state_d = rx ? ST_ID_B : ST_R0;
                    end
                    ST_ID_B: begin
                        id_d      = {id_q[27:0], rx};
                        crc_d     = crc_step(crc_q, rx);
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd17) begin
                            state_d   = ST_RTR_X;
                            bit_cnt_d = '0;
                        end
                    end
                    ST_RTR_X: begin
                        rtr_d   = rx;
                        crc_d   = crc_step(crc_q, rx);
                        state_d = ST_R1;
                    end
                    ST_R1: begin
                        crc_d   = crc_step(crc_q, rx);
                        state_d = ST_R0;
                    end
                    ST_R0: begin
                        crc_d     = crc_step(crc_q, rx);
                        state_d   = ST_DLC;
                        bit_cnt_d = '0;
                    end
                    ST_DLC: begin
                        dlc_d     = {dlc_q[2:0], rx};
                        crc_d     = crc_step(crc_q, rx);
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd3) begin
                            bit_cnt_d = '0;
                            state_d   = (rtr_q || dlc_d == 4'd0) ? ST_CRC : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        data_d[6'd63 - bit_cnt_q] = rx;
                        crc_d     = crc_step(crc_q, rx);
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if ({1'b0, bit_cnt_q} == data_bits - 7'd1) begin
                            state_d   = ST_CRC;
                            bit_cnt_d = '0;
                        end
                    end
                    ST_CRC: begin
                        crc_rx_d  = {crc_rx_q[13:0], rx};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd14) begin
                            state_d   = ST_CRC_DEL;
                            bit_cnt_d = '0;
                        end
                    end
                    ST_CRC_DEL: begin
                        if (crc_rx_q != crc_q) begin
                            crc_err_d = 1'b1;
                            crc_bad_d = 1'b1;
                        end
                        if (!rx) begin
                            form_err_d = 1'b1;
                            state_d    = ST_ERROR;
                            recov_d    = '0;
                        end else begin
                            state_d = ST_ACK_SLOT;
                        end
                    end
                    ST_ACK_SLOT: begin
                        ack_d   = ~rx;
                        state_d = ST_ACK_DEL;
                    end
                    ST_ACK_DEL: begin
                        bit_cnt_d = '0;
                        if (!rx) begin
                            form_err_d = 1'b1;
                            state_d    = ST_ERROR;
                            recov_d    = '0;
                        end else begin
                            state_d = ST_EOF;
                        end
                    end
                    ST_EOF: begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (!rx) begin
                            form_err_d = 1'b1;
                            state_d    = ST_ERROR;
                            recov_d    = '0;
                        end else if (bit_cnt_q == 6'd6) begin
                            frame_valid_d = ~crc_bad_q;
                            state_d       = ST_IDLE;
                            bit_cnt_d     = '0;
                        end
                    end
                    ST_ERROR: begin
                        if (!rx) begin
                            recov_d = '0;
                        end else if (recov_q == RECOVER_LAST) begin
                            recov_d = '0;
                            state_d = ST_IDLE;
                        end else begin
                            recov_d = recov_q + RW'(1);
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        stuff_en    = stuffed;
        busy        = (state_q != ST_IDLE);
        state       = state_q;
        stuff_bit   = stuff_bit_q;
        stuff_err   = stuff_err_q;
        form_err    = form_err_q;
        crc_err     = crc_err_q;
        frame_valid = frame_valid_q;
        id          = id_q;
        ide         = ide_q;
        rtr         = rtr_q;
        dlc         = dlc_q;
        data        = data_q;
        ack_seen    = ack_q;
    end

endmodule

// File: tb/tb_can_rx_frame_sequencer.sv
// Bench for can_rx_frame_sequencer: a frame-level model builds stuffed bit streams
// and pushes the expected outcome; a monitor pops and compares on every DUT event.
module tb_can_rx_frame_sequencer;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_DATA = 4'd9, ST_ACK_SLOT = 4'd12, ST_ERROR = 4'd15;
    localparam logic [3:0] K_FV = 4'b1000, K_CRC = 4'b0100, K_STUFF = 4'b0010, K_FORM = 4'b0001;

    logic        clk = 1'b0, reset = 1'b0, rx = 1'b1, sp = 1'b0;
    logic        stuff_en, stuff_bit, stuff_err, form_err, crc_err, frame_valid;
    logic [28:0] id;
    logic        ide, rtr, ack_seen, busy;
    logic [3:0]  dlc, state;
    logic [63:0] data;

    can_rx_frame_sequencer #(.RECOVER_BITS(11)) dut (
        .clk(clk), .reset(reset), .rx(rx), .sp(sp),
        .stuff_en(stuff_en), .stuff_bit(stuff_bit), .stuff_err(stuff_err),
        .form_err(form_err), .crc_err(crc_err), .frame_valid(frame_valid),
        .id(id), .ide(ide), .rtr(rtr), .dlc(dlc), .data(data),
        .ack_seen(ack_seen), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        ack;
        int          stuffs;
        logic [3:0]  st;
    } exp_t;

    exp_t exp_q[$];
    logic raw_q[$];
    logic strm[$];
    int   m_stuffs;
    int   n_checks = 0, n_pass = 0;
    int   mon_stuffs = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // CRC as the remainder of (message * x^15) divided by x^15 + 0x4599, by long division.
    function automatic logic [14:0] crc_model();
        logic m[$];
        logic [15:0] gen;
        logic [14:0] r;
        gen = 16'hC599;
        m = raw_q;
        for (int k = 0; k < 15; k++) m.push_back(1'b0);
        for (int i = 0; i + 16 <= m.size(); i++)
            if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ gen[15-j];
        for (int k = 0; k < 15; k++) r[14-k] = m[m.size()-15+k];
        return r;
    endfunction

    task automatic build_frame(input logic ext, input logic [28:0] fid, input logic frtr,
                               input logic [3:0] fdlc, input logic [63:0] fdata, input logic ackd,
                               input int crc_flip, input int eof_bad, output exp_t e);
        int nbytes, run;
        logic lvl;
        logic [14:0] c;
        raw_q.delete();
        raw_q.push_back(1'b0);
        if (!ext) begin
            for (int i = 10; i >= 0; i--) raw_q.push_back(fid[i]);
            raw_q.push_back(frtr);
            raw_q.push_back(1'b0);
            raw_q.push_back(1'($urandom % 2));
        end else begin
            for (int i = 28; i >= 18; i--) raw_q.push_back(fid[i]);
            raw_q.push_back(1'b1);
            raw_q.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw_q.push_back(fid[i]);
            raw_q.push_back(frtr);
            raw_q.push_back(1'($urandom % 2));
            raw_q.push_back(1'($urandom % 2));
        end
        for (int i = 3; i >= 0; i--) raw_q.push_back(fdlc[i]);
        nbytes = frtr ? 0 : ((fdlc > 8) ? 8 : int'(fdlc));
        e.data = '0;
        for (int i = 0; i < nbytes * 8; i++) begin
            raw_q.push_back(fdata[63-i]);
            e.data[63-i] = fdata[63-i];
        end
        c = crc_model();
        if (crc_flip >= 0) c[crc_flip] = ~c[crc_flip];
        for (int i = 14; i >= 0; i--) raw_q.push_back(c[i]);
        strm.delete();
        m_stuffs = 0;
        run = 0;
        lvl = 1'b0;
        for (int i = 0; i < raw_q.size(); i++) begin
            if (run == 5) begin
                strm.push_back(~lvl);
                m_stuffs++;
                lvl = ~lvl;
                run = 1;
            end
            strm.push_back(raw_q[i]);
            if (run > 0 && raw_q[i] == lvl) run++;
            else begin
                lvl = raw_q[i];
                run = 1;
            end
        end
        strm.push_back(1'b1);
        strm.push_back(ackd ? 1'b0 : 1'b1);
        strm.push_back(1'b1);
        for (int k = 0; k < 7; k++) strm.push_back((k == eof_bad) ? 1'b0 : 1'b1);
        e.kind   = (eof_bad >= 0) ? K_FORM : (crc_flip >= 0) ? K_CRC : K_FV;
        e.st     = (eof_bad >= 0) ? ST_ERROR : (crc_flip >= 0) ? ST_ACK_SLOT : ST_IDLE;
        e.id     = ext ? fid : {18'b0, fid[10:0]};
        e.ide    = ext;
        e.rtr    = frtr;
        e.dlc    = fdlc;
        e.ack    = ackd;
        e.stuffs = m_stuffs;
    endtask

    task automatic send_bit(input logic b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1;
        rx = b;
        sp = 1'b1;
        @(posedge clk); #1;
        sp = 1'b0;
    endtask

    task automatic send_stream();
        for (int i = 0; i < strm.size(); i++) send_bit(strm[i]);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    logic [3:0] ev;
    exp_t       me;
    always @(negedge clk) begin
        if (reset) mon_stuffs = 0;
        else begin
            if (stuff_bit) mon_stuffs++;
            ev = {frame_valid, crc_err, stuff_err, form_err};
            if (ev != 4'b0) begin
                if (exp_q.size() == 0) chk("unexpected_event", 128'(ev), 128'(0));
                else begin
                    me = exp_q.pop_front();
                    chk("event_kind", 128'(ev), 128'(me.kind));
                    chk("event_state", 128'(state), 128'(me.st));
                    chk("stuff_count", 128'(mon_stuffs), 128'(me.stuffs));
                    if (me.kind == K_FV) begin
                        chk("id", 128'(id), 128'(me.id));
                        chk("ide", 128'(ide), 128'(me.ide));
                        chk("rtr", 128'(rtr), 128'(me.rtr));
                        chk("dlc", 128'(dlc), 128'(me.dlc));
                        chk("data", 128'(data), 128'(me.data));
                        chk("ack_seen", 128'(ack_seen), 128'(me.ack));
                    end
                end
                mon_stuffs = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   sel, cf, eb, wait_cyc;
        logic ext;
        logic [28:0] tid;

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {stuff_en, stuff_bit, stuff_err, form_err, crc_err, frame_valid,
                              id, ide, rtr, dlc, data, ack_seen, busy, state}, '0);
        reset = 1'b0;

        build_frame(1'b0, 29'h123, 1'b0, 4'd1, {8'hA5, 56'h0}, 1'b1, -1, -1, e);
        exp_q.push_back(e);
        send_stream();
        idle_bits(3);
        chk("hold_id", 128'(id), 128'(29'h123));
        chk("hold_data_byte0", 128'(data[63:56]), 128'(8'hA5));

        build_frame(1'b1, 29'h1ABCDEF0, 1'b1, 4'd4, {$urandom, $urandom}, 1'b1, -1, -1, e);
        exp_q.push_back(e);
        send_stream();
        idle_bits(3);

        e.kind = K_STUFF; e.st = ST_ERROR; e.stuffs = 0;
        exp_q.push_back(e);
        send_bit(1'b0);
        chk("sof_stuff_en", 128'(stuff_en), 128'(1));
        chk("sof_busy", 128'(busy), 128'(1));
        repeat (5) send_bit(1'b0);
        chk("stuff_err_state", 128'(state), 128'(ST_ERROR));
        chk("error_stuff_en", 128'(stuff_en), 128'(0));
        idle_bits(10);
        chk("recover_10", 128'(state), 128'(ST_ERROR));
        idle_bits(1);
        chk("recover_11", 128'(state), 128'(ST_IDLE));

        build_frame(1'b0, 29'h2B7, 1'b0, 4'd3, {$urandom, $urandom}, 1'b0, 7, -1, e);
        exp_q.push_back(e);
        send_stream();
        idle_bits(3);
        chk("crc_err_to_idle", 128'(state), 128'(ST_IDLE));

        build_frame(1'b0, 29'h055, 1'b0, 4'd2, {$urandom, $urandom}, 1'b1, -1, 2, e);
        exp_q.push_back(e);
        send_stream();
        idle_bits(12);
        chk("form_recover", 128'(state), 128'(ST_IDLE));

        build_frame(1'b0, 29'h3C1, 1'b0, 4'd8, {$urandom, $urandom}, 1'b1, -1, -1, e);
        for (int i = 0; i < 35; i++) send_bit(strm[i]);
        chk("in_data", 128'(state), 128'(ST_DATA));
        reset = 1'b1;
        #1;
        chk("midframe_reset", {stuff_en, stuff_bit, stuff_err, form_err, crc_err, frame_valid,
                               id, ide, rtr, dlc, data, ack_seen, busy, state}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        build_frame(1'b0, 29'h6E9, 1'b0, 4'd8, {$urandom, $urandom}, 1'b1, -1, -1, e);
        exp_q.push_back(e);
        send_stream();
        idle_bits(3);

        for (int n = 0; n < 40; n++) begin
            ext = 1'($urandom % 2);
            tid = 29'($urandom);
            if (!ext) tid = {18'b0, tid[10:0]};
            sel = int'($urandom % 8);
            cf  = (sel == 0) ? int'($urandom % 15) : -1;
            eb  = (sel == 1) ? int'($urandom % 7) : -1;
            build_frame(ext, tid, 1'($urandom % 4 == 0), 4'($urandom), {$urandom, $urandom},
                        1'($urandom % 2), cf, eb, e);
            exp_q.push_back(e);
            send_stream();
            idle_bits((eb >= 0) ? 12 : 3);
            chk("rand_end_idle", 128'(state), 128'(ST_IDLE));
        end

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 200) begin
            @(posedge clk);
            wait_cyc++;
        end
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
